// File: rtl/flash_cmd_seq_if.sv
// Purpose: bus between flash_cmd_seq and the SPI controller (spictl).
// Signals:
//   spi_trig        frame start strobe, one cycle
//   spi_datalength  number of bits in the frame
//   spi_senddata    frame bits, right-aligned, bit datalength-1 sent first
//   spi_isbusy      spictl has a frame in flight
//   spi_recvdata    received bits, right-aligned, last bit in bit 0
// master = sequencer side, slave = spictl side.
interface flash_cmd_seq_if;
  logic         spi_trig;
  logic [7:0]   spi_datalength;
  logic [127:0] spi_senddata;
  logic         spi_isbusy;
  logic [127:0] spi_recvdata;

  modport master (
    output spi_trig, spi_datalength, spi_senddata,
    input  spi_isbusy, spi_recvdata
  );

  modport slave (
    input  spi_trig, spi_datalength, spi_senddata,
    output spi_isbusy, spi_recvdata
  );
endinterface

// File: rtl/flash_cmd_seq.sv
// Purpose: SPI-NOR command sequencer. Turns a one-cycle op request into the
// full frame sequence for spictl: RDSR, RDID, READ, PP, SE, CE. Write-class
// ops (PP/SE/CE) issue WREN first and then poll RDSR until WIP clears.
// Ports:
//   sclk, rst           clock, synchronous active-high reset
//   start/op/addr/wdata request pulse and its operands
//   busy/done/error     status; error is valid with the done pulse
//   result              read data, valid from done until the next done
//   spi                 master side of the spictl bus
// BUSY_WAIT and POLL_GAP must be at least 1.
module flash_cmd_seq #(
  parameter int unsigned BUSY_WAIT = 16,
  parameter int unsigned POLL_GAP  = 1000,
  parameter int unsigned POLL_MAX  = 100000
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [23:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [23:0] result,
  flash_cmd_seq_if.master spi
);

  localparam int unsigned CW = 32;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_WAIT_END = 3'd3;
  localparam logic [2:0] S_GAP      = 3'd4;
  localparam logic [2:0] S_ILLEGAL  = 3'd5;

  // Frame kinds share the op encoding; WREN takes the first illegal code.
  localparam logic [2:0] OP_RDSR = 3'd0;
  localparam logic [2:0] OP_RDID = 3'd1;
  localparam logic [2:0] OP_READ = 3'd2;
  localparam logic [2:0] OP_PP   = 3'd3;
  localparam logic [2:0] OP_SE   = 3'd4;
  localparam logic [2:0] OP_CE   = 3'd5;
  localparam logic [2:0] K_WREN  = 3'd6;

  localparam logic [1:0] P_WREN = 2'd0;
  localparam logic [1:0] P_CMD  = 2'd1;
  localparam logic [1:0] P_POLL = 2'd2;

  logic [2:0]    state, state_nxt;
  logic [1:0]    phase, phase_nxt;
  logic [2:0]    op_q, op_nxt;
  logic [23:0]   addr_q, addr_nxt;
  logic [7:0]    wdata_q, wdata_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] poll_cnt, poll_nxt;
  logic          busy_nxt, done_nxt, error_nxt;
  logic [23:0]   result_nxt;
  logic          trig_q, trig_nxt;
  logic [7:0]    len_q, len_nxt;
  logic [127:0]  data_q, data_nxt;
  logic [2:0]    kind_nxt;
  logic [135:0]  frame_nxt;
  logic          fin, fin_err;
  logic          isbusy;
  logic [7:0]    status;
  logic          unused_recv;

  assign isbusy             = spi.spi_isbusy;
  assign status             = spi.spi_recvdata[7:0];
  assign unused_recv        = ^spi.spi_recvdata[127:24];
  assign spi.spi_trig       = trig_q;
  assign spi.spi_datalength = len_q;
  assign spi.spi_senddata   = data_q;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // {datalength, senddata} for a frame kind; dummy bits are zero.
  function automatic logic [135:0] frame_for(input logic [2:0] kind,
                                             input logic [23:0] a,
                                             input logic [7:0] d);
    logic [135:0] f;
    case (kind)
      OP_RDSR: f = {8'd16, 112'h0, 8'h05, 8'h00};
      OP_RDID: f = {8'd32, 96'h0, 8'h9F, 24'h0};
      OP_READ: f = {8'd40, 88'h0, 8'h03, a, 8'h00};
      OP_PP:   f = {8'd40, 88'h0, 8'h02, a, d};
      OP_SE:   f = {8'd32, 96'h0, 8'h20, a};
      OP_CE:   f = {8'd8, 120'h0, 8'hC7};
      K_WREN:  f = {8'd8, 120'h0, 8'h06};
      default: f = '0;
    endcase
    return f;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    op_nxt     = op_q;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    cnt_nxt    = cnt;
    poll_nxt   = poll_cnt;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    error_nxt  = error;
    result_nxt = result;
    trig_nxt   = 1'b0;
    len_nxt    = len_q;
    data_nxt   = data_q;
    kind_nxt   = K_WREN;
    frame_nxt  = '0;
    fin        = 1'b0;
    fin_err    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start && !isbusy) begin
          op_nxt    = op;
          addr_nxt  = addr;
          wdata_nxt = wdata;
          busy_nxt  = 1'b1;
          error_nxt = 1'b0;
          if (op > OP_CE) begin
            state_nxt = S_ILLEGAL;
          end else begin
            phase_nxt = (op >= OP_PP) ? P_WREN : P_CMD;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ILLEGAL: begin
        fin     = 1'b1;
        fin_err = 1'b1;
      end
      S_ISSUE: begin
        state_nxt = S_WAIT_ACK;
        cnt_nxt   = '0;
      end
      S_WAIT_ACK: begin
        if (isbusy) begin
          state_nxt = S_WAIT_END;
        end else if (cnt == CW'(BUSY_WAIT - 1)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      S_WAIT_END: begin
        if (!isbusy) begin
          case (phase)
            P_WREN: begin
              phase_nxt = P_CMD;
              state_nxt = S_ISSUE;
            end
            P_CMD: begin
              case (op_q)
                OP_RDSR: begin
                  result_nxt = {16'h0, status};
                  fin        = 1'b1;
                end
                OP_RDID: begin
                  result_nxt = spi.spi_recvdata[23:0];
                  fin        = 1'b1;
                end
                OP_READ: begin
                  result_nxt = {16'h0, status};
                  fin        = 1'b1;
                end
                default: begin
                  phase_nxt = P_POLL;
                  poll_nxt  = '0;
                  state_nxt = S_ISSUE;
                end
              endcase
            end
            default: begin
              // Poll: WIP is status bit 0.
              if (!status[0]) begin
                result_nxt = {16'h0, status};
                fin        = 1'b1;
              end else if (sat_inc(poll_cnt) == CW'(POLL_MAX)) begin
                fin     = 1'b1;
                fin_err = 1'b1;
              end else begin
                poll_nxt  = sat_inc(poll_cnt);
                cnt_nxt   = '0;
                state_nxt = S_GAP;
              end
            end
          endcase
        end
      end
      S_GAP: begin
        if (cnt == CW'(POLL_GAP - 1)) begin
          state_nxt = S_ISSUE;
        end else begin
          cnt_nxt = sat_inc(cnt);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (fin) begin
      state_nxt = S_IDLE;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b1;
      error_nxt = fin_err;
    end

    // Load the frame on entry to ISSUE so trig and data appear together.
    if (state_nxt == S_ISSUE) begin
      case (phase_nxt)
        P_WREN:  kind_nxt = K_WREN;
        P_POLL:  kind_nxt = OP_RDSR;
        default: kind_nxt = op_nxt;
      endcase
      frame_nxt = frame_for(kind_nxt, addr_nxt, wdata_nxt);
      trig_nxt  = 1'b1;
      len_nxt   = frame_nxt[135:128];
      data_nxt  = frame_nxt[127:0];
    end
  end

  // State and output registers.
  always_ff @(posedge sclk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= P_WREN;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt      <= '0;
      poll_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      result   <= '0;
      trig_q   <= 1'b0;
      len_q    <= '0;
      data_q   <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      op_q     <= op_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      cnt      <= cnt_nxt;
      poll_cnt <= poll_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
      result   <= result_nxt;
      trig_q   <= trig_nxt;
      len_q    <= len_nxt;
      data_q   <= data_nxt;
    end
  end

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Purpose: directed bench for flash_cmd_seq with a behavioural spictl model.
module tb_flash_cmd_seq;

  localparam int unsigned BW = 16;
  localparam int unsigned PG = 5;
  localparam int unsigned PM = 4;

  logic        sclk  = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = '0;
  logic [23:0] addr  = '0;
  logic [7:0]  wdata = '0;
  logic        busy, done, error;
  logic [23:0] result;

  flash_cmd_seq_if bus();

  flash_cmd_seq #(.BUSY_WAIT(BW), .POLL_GAP(PG), .POLL_MAX(PM)) dut (
    .sclk   (sclk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .addr   (addr),
    .wdata  (wdata),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .result (result),
    .spi    (bus)
  );

  always #5 sclk = ~sclk;

  // spictl model: isbusy rises the cycle after trig, stays high for lat cycles.
  logic         m_busy = 1'b0;
  logic [127:0] m_recv = '0;
  logic [127:0] m_resp = '0;
  int           m_rem  = 0;
  int           m_rdsr = 0;
  int           cyc    = 0;
  int           lat       = 3;
  bit           no_ack    = 1'b0;
  bit           wip_stuck = 1'b0;
  int           wip_polls = 0;

  logic [7:0]   q_len[$];
  logic [127:0] q_data[$];
  int           q_cyc[$];

  assign bus.spi_isbusy   = m_busy;
  assign bus.spi_recvdata = m_recv;

  always @(posedge sclk) begin
    cyc <= cyc + 1;
    if (bus.spi_trig) begin
      q_len.push_back(bus.spi_datalength);
      q_data.push_back(bus.spi_senddata);
      q_cyc.push_back(cyc);
    end
    if (m_busy) begin
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_recv <= m_resp;
      end else begin
        m_rem <= m_rem - 1;
      end
    end else if (bus.spi_trig && !no_ack) begin
      m_busy <= 1'b1;
      m_rem  <= lat;
      if (bus.spi_datalength == 8'd8 && bus.spi_senddata[7:0] == 8'h06) begin
        m_rdsr <= 0;
        m_resp <= '0;
      end else if (bus.spi_datalength == 8'd16 && bus.spi_senddata[15:8] == 8'h05) begin
        m_rdsr <= m_rdsr + 1;
        m_resp <= (wip_stuck || m_rdsr < wip_polls) ? 128'h03 : 128'h00;
      end else if (bus.spi_datalength == 8'd32 && bus.spi_senddata[31:24] == 8'h9F) begin
        m_resp <= 128'hEF4018;
      end else if (bus.spi_datalength == 8'd40 && bus.spi_senddata[39:32] == 8'h03) begin
        m_resp <= 128'h5A;
      end else begin
        m_resp <= '0;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [23:0] a, input logic [7:0] d);
    op    = o;
    addr  = a;
    wdata = d;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      if (done) seen = 1'b1;
    end
    chk(tag, 128'(seen), 128'd1);
  endtask

  task automatic wait_trig(input string tag, input logic [127:0] data);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      if (bus.spi_trig && bus.spi_senddata == data) seen = 1'b1;
      else step();
    end
    chk(tag, 128'(seen), 128'd1);
  endtask

  task automatic chk_frame(input string tag, input int i, input logic [7:0] len,
                           input logic [127:0] data);
    if (i < q_len.size()) begin
      chk({tag, "_len"}, 128'(q_len[i]), 128'(len));
      chk({tag, "_data"}, q_data[i], data);
    end else begin
      chk({tag, "_present"}, 128'(q_len.size()), 128'(i + 1));
    end
  endtask

  task automatic clear_log();
    q_len.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  int t0;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_error", 128'(error), 128'd0);
    chk("rst_trig", 128'(bus.spi_trig), 128'd0);
    chk("rst_result", 128'(result), 128'd0);
    chk("rst_len", 128'(bus.spi_datalength), 128'd0);
    chk("rst_data", bus.spi_senddata, 128'd0);
    rst = 1'b0;
    step();

    // RDID
    clear_log();
    issue(3'd1, 24'h0, 8'h0);
    chk("rdid_busy", 128'(busy), 128'd1);
    wait_done("rdid_done");
    chk("rdid_error", 128'(error), 128'd0);
    chk("rdid_result", 128'(result), 128'hEF4018);
    chk("rdid_busy_low", 128'(busy), 128'd0);
    chk("rdid_nframes", 128'(q_len.size()), 128'd1);
    chk_frame("rdid_f0", 0, 8'd32, 128'h9F000000);

    // PP with WIP set for three polls
    clear_log();
    wip_polls = 3;
    issue(3'd3, 24'h012345, 8'hA5);
    wait_done("pp_done");
    chk("pp_error", 128'(error), 128'd0);
    chk("pp_result", 128'(result), 128'd0);
    chk("pp_nframes", 128'(q_len.size()), 128'd6);
    chk_frame("pp_wren", 0, 8'd8, 128'h06);
    chk_frame("pp_cmd", 1, 8'd40, 128'h02012345A5);
    for (int i = 2; i < 6; i++) chk_frame("pp_rdsr", i, 8'd16, 128'h0500);
    if (q_cyc.size() >= 4)
      chk("pp_gap", 128'(q_cyc[3] - q_cyc[2]), 128'(lat + 2 + int'(PG)));
    else
      chk("pp_gap_frames", 128'(q_cyc.size()), 128'd4);
    wip_polls = 0;
    step();

    // CE with WIP stuck: poll limit
    clear_log();
    wip_stuck = 1'b1;
    issue(3'd5, 24'h0, 8'h0);
    wait_done("ce_done");
    chk("ce_error", 128'(error), 128'd1);
    chk("ce_nframes", 128'(q_len.size()), 128'd6);
    chk_frame("ce_wren", 0, 8'd8, 128'h06);
    chk_frame("ce_cmd", 1, 8'd8, 128'hC7);
    chk_frame("ce_rdsr_first", 2, 8'd16, 128'h0500);
    chk_frame("ce_rdsr_last", 5, 8'd16, 128'h0500);
    wip_stuck = 1'b0;
    step();

    // spictl never acknowledges
    clear_log();
    no_ack = 1'b1;
    issue(3'd0, 24'h0, 8'h0);
    wait_trig("noack_trig", 128'h0500);
    t0 = cyc;
    wait_done("noack_done");
    chk("noack_delay", 128'(cyc - t0), 128'(BW + 1));
    chk("noack_error", 128'(error), 128'd1);
    no_ack = 1'b0;
    step();

    // READ with a start pulse while busy
    clear_log();
    issue(3'd2, 24'h000100, 8'h0);
    step();
    op    = 3'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("read_done");
    chk("read_error", 128'(error), 128'd0);
    chk("read_result", 128'(result), 128'h5A);
    repeat (20) step();
    chk("read_nframes", 128'(q_len.size()), 128'd1);
    chk_frame("read_f0", 0, 8'd40, 128'h0300010000);

    // Illegal op
    clear_log();
    issue(3'd7, 24'h0, 8'h0);
    chk("ill_busy", 128'(busy), 128'd1);
    chk("ill_done_early", 128'(done), 128'd0);
    step();
    chk("ill_done", 128'(done), 128'd1);
    chk("ill_error", 128'(error), 128'd1);
    chk("ill_busy_low", 128'(busy), 128'd0);
    chk("ill_result", 128'(result), 128'h5A);
    step();
    chk("ill_done_pulse", 128'(done), 128'd0);
    chk("ill_nframes", 128'(q_len.size()), 128'd0);

    // Reset in WAIT_END of CE, then start while spictl still busy
    clear_log();
    lat       = 6;
    wip_stuck = 1'b1;
    issue(3'd5, 24'h0, 8'h0);
    wait_trig("rce_trig", 128'hC7);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rce_busy", 128'(busy), 128'd0);
    chk("rce_trig_low", 128'(bus.spi_trig), 128'd0);
    chk("rce_done", 128'(done), 128'd0);
    chk("rce_spi_busy", 128'(m_busy), 128'd1);
    issue(3'd1, 24'h0, 8'h0);
    chk("rce_dropped", 128'(busy), 128'd0);
    repeat (10) step();
    chk("rce_nframes", 128'(q_len.size()), 128'd2);
    wip_stuck = 1'b0;
    issue(3'd1, 24'h0, 8'h0);
    wait_done("rce_rdid_done");
    chk("rce_rdid_result", 128'(result), 128'hEF4018);
    chk("rce_rdid_error", 128'(error), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_cmd_seq.md
Name: flash_cmd_seq

Overview:
- Command sequencer directly upstream of the SPI controller (spictl); drives its trig/datalength/senddata inputs and consumes isbusy/recvdata.
- Turns one-cycle op requests into complete SPI-NOR flash transactions: read status, read ID, read byte, page-program byte, sector erase, chip erase.
- Write-class ops automatically issue WREN (0x06) first, then poll RDSR until WIP clears.

Parameters:
- BUSY_WAIT, 16: max cycles from spi_trig to spi_isbusy high before error.
- POLL_GAP, 1000: idle cycles between consecutive RDSR polls.
- POLL_MAX, 100000: max RDSR polls per write op before timeout error.

Ports:
- sclk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request pulse; op/addr/wdata sampled with it
- op  in  3  0 RDSR, 1 RDID, 2 READ, 3 PP, 4 SE, 5 CE, 6-7 illegal
- addr  in  24  flash byte address (READ/PP/SE)
- wdata  in  8  program byte (PP)
- busy  out  1  op in progress
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; 1 = timeout or illegal op
- result  out  24  read data, valid from done until next done
- spi_trig  out  1  to spictl trig
- spi_datalength  out  8  bits in frame
- spi_senddata  out  128  frame, right-aligned, bit datalength-1 sent first
- spi_isbusy  in  1  from spictl
- spi_recvdata  in  128  received bits, right-aligned, last bit in bit 0

Behaviour:
- Reset: busy, done, error, spi_trig = 0; result, spi_datalength, spi_senddata = 0; FSM to IDLE; counters cleared. Reset mid-op abandons the op with no done pulse. spictl is not reset; a frame already in flight completes on its own.
- Acceptance: start is accepted only in IDLE with spi_isbusy = 0. Any other start is dropped, not queued. busy rises the cycle after acceptance and falls with done.
- Illegal op (6, 7): busy for 1 cycle, then done = 1, error = 1, result unchanged.
- Frame primitive, states ISSUE -> WAIT_ACK -> WAIT_END:
  - ISSUE: spi_trig = 1 for exactly one cycle. spi_datalength/spi_senddata load that cycle and stay stable until WAIT_END exits.
  - WAIT_ACK: wait for spi_isbusy = 1. If absent for BUSY_WAIT cycles, abort op: done = 1, error = 1.
  - WAIT_END: wait for spi_isbusy = 0, then capture spi_recvdata the same cycle.
- Frames, with dummy bits = 0:
  - WREN: 8 bits, 0x06.
  - RDSR: 16 bits, {0x05, 8'h00}; status = recvdata[7:0].
  - RDID: 32 bits, {0x9F, 24'h0}; result = recvdata[23:0].
  - READ: 40 bits, {0x03, addr, 8'h00}; result = {16'h0, recvdata[7:0]}.
  - PP: 40 bits, {0x02, addr, wdata}.
  - SE: 32 bits, {0x20, addr}.
  - CE: 8 bits, 0xC7.
- Op flows:
  - RDSR: one frame; result = {16'h0, status}.
  - RDID, READ: one frame each.
  - PP, SE, CE: WREN -> command -> POLL loop. In POLL, issue an RDSR frame. If status[0] = 0, done with error = 0 and result = {16'h0, status}. Otherwise increment poll count; if count = POLL_MAX, done with error = 1. Otherwise wait POLL_GAP cycles in GAP and repeat.
- done fires the cycle after the final WAIT_END exit; the FSM returns to IDLE on the same edge. A new start is accepted the cycle after done.
- Counters: 32-bit, saturating, cleared on every state entry that uses them.

Test Plan:
- Reset while in WAIT_END of CE -> next cycle busy = 0, spi_trig = 0, done = 0; start then accepted once spi_isbusy = 0.
- op = 1, model returns 0xEF4018 -> one frame, datalength 32, senddata = 0x9F000000; done with result = 0xEF4018, error = 0.
- op = 3, addr = 0x012345, wdata = 0xA5, model WIP = 1 for 3 polls -> frame sequence:
  - 0x06 (len 8)
  - 0x02012345A5 (len 40)
  - four RDSR frames 0x0500, with POLL_GAP idle cycles between polls
  - done, error = 0.
- op = 5 (POLL_MAX = 4), WIP stuck at 1 -> frames 0x06, 0xC7, then exactly 4 RDSR frames; done with error = 1.
- spictl model never raises isbusy -> done with error = 1 exactly BUSY_WAIT + 1 cycles after spi_trig.
- start pulsed while busy, or op = 7 -> the busy-time start is ignored (no extra frame); op = 7 gives done, error = 1, and no spi_trig.
